store_buffer: RTL and testbench



---
 rtl/riscv_pkg.sv | 24 ++
 rtl/sb_overlap.sv | 26 ++
 rtl/store_buffer.sv | 119 +++++++++++
 tb/tb_store_buffer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared memory-access encodings and the type-to-size helper.
`default_nettype none

package riscv_pkg;

  localparam logic [2:0] DM_B  = 3'b000;
  localparam logic [2:0] DM_H  = 3'b001;
  localparam logic [2:0] DM_W  = 3'b010;
  localparam logic [2:0] DM_BU = 3'b100;
  localparam logic [2:0] DM_HU = 3'b101;
  localparam logic [2:0] DM_WU = 3'b110;

  // Unknown encodings are treated as a full word so overlap checks stay conservative.
  function automatic logic [2:0] dm_size(input logic [2:0] t);
    case (t)
      DM_B, DM_BU: dm_size = 3'd1;
      DM_H, DM_HU: dm_size = 3'd2;
      default:     dm_size = 3'd4;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/sb_overlap.sv
// Combinational byte-range overlap test between two (addr, type) accesses.
`default_nettype none

module sb_overlap
  import riscv_pkg::*;
(
  input  logic [31:0] a_addr_i,
  input  logic [2:0]  a_type_i,
  input  logic [31:0] b_addr_i,
  input  logic [2:0]  b_type_i,
  output logic        overlap_o
);

  logic [32:0] w_a_start, w_a_end, w_b_start, w_b_end;

  // 33-bit range ends keep accesses near the top of memory from wrapping to 0.
  assign w_a_start = {1'b0, a_addr_i};
  assign w_b_start = {1'b0, b_addr_i};
  assign w_a_end   = w_a_start + 33'(dm_size(a_type_i)) - 33'd1;
  assign w_b_end   = w_b_start + 33'(dm_size(b_type_i)) - 33'd1;

  assign overlap_o = (w_a_start <= w_b_end) && (w_b_start <= w_a_end);

endmodule

`default_nettype wire

// File: rtl/store_buffer.sv
// In-order store buffer: queues committed stores, drains one per cycle to data
// memory, and stalls loads that overlap any pending or incoming store.
`default_nettype none

module store_buffer
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             st_valid,
  output logic             st_ready,
  input  logic [2:0]       st_type,
  input  logic [31:0]      st_addr,
  input  logic [31:0]      st_data,
  input  logic             ld_valid,
  input  logic [2:0]       ld_type,
  input  logic [31:0]      ld_addr,
  output logic             ld_stall,
  input  logic             drain_en,
  output logic             MemWrite,
  output logic [2:0]       DMType,
  output logic [31:0]      Address,
  output logic [31:0]      Write_data,
  output logic             empty,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [2:0]       type_q [DEPTH];
  logic [31:0]      addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;

  logic             w_push, w_pop, w_st_type_ok;
  logic [DEPTH-1:0] w_entry_valid, w_entry_ovl;
  logic             w_in_ovl;

  assign empty    = (count_q == '0);
  assign st_ready = (count_q != FULL_CNT);
  assign count    = count_q;

  assign w_st_type_ok = (st_type == DM_B) || (st_type == DM_H) || (st_type == DM_W);
  assign w_push       = st_valid && st_ready && w_st_type_ok;
  assign w_pop        = MemWrite;

  assign MemWrite   = !empty && drain_en;
  assign DMType     = empty ? 3'd0  : type_q[head_q];
  assign Address    = empty ? 32'd0 : addr_q[head_q];
  assign Write_data = empty ? 32'd0 : data_q[head_q];

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (w_push) tail_d = tail_q + PTR_W'(1);
    if (w_pop)  head_d = head_q + PTR_W'(1);
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry payload needs no reset: occupancy is tracked solely by count_q.
  always_ff @(posedge clk) begin
    if (w_push) begin
      type_q[tail_q] <= st_type;
      addr_q[tail_q] <= st_addr;
      data_q[tail_q] <= st_data;
    end
  end

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
      logic [PTR_W-1:0] w_offset;
      assign w_offset         = PTR_W'(i) - head_q;
      assign w_entry_valid[i] = ({1'b0, w_offset} < count_q);

      sb_overlap u_ovl (
        .a_addr_i  (addr_q[i]),
        .a_type_i  (type_q[i]),
        .b_addr_i  (ld_addr),
        .b_type_i  (ld_type),
        .overlap_o (w_entry_ovl[i])
      );
    end
  endgenerate

  sb_overlap u_ovl_in (
    .a_addr_i  (st_addr),
    .a_type_i  (st_type),
    .b_addr_i  (ld_addr),
    .b_type_i  (ld_type),
    .overlap_o (w_in_ovl)
  );

  assign ld_stall = ld_valid && ((|(w_entry_ovl & w_entry_valid)) || (w_push && w_in_ovl));

endmodule

`default_nettype wire

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus random traffic
// compared against a queue-based reference model.
`default_nettype none

module tb_store_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid, st_ready;
  logic [2:0]  st_type;
  logic [31:0] st_addr, st_data;
  logic        ld_valid;
  logic [2:0]  ld_type;
  logic [31:0] ld_addr;
  logic        ld_stall, drain_en, MemWrite, empty;
  logic [2:0]  DMType;
  logic [31:0] Address, Write_data;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  typedef struct { logic [2:0] t; logic [31:0] a; logic [31:0] d; } entry_t;
  entry_t q[$];

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(4), .PTR_W(2)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_ready(st_ready), .st_type(st_type),
    .st_addr(st_addr), .st_data(st_data),
    .ld_valid(ld_valid), .ld_type(ld_type), .ld_addr(ld_addr), .ld_stall(ld_stall),
    .drain_en(drain_en), .MemWrite(MemWrite), .DMType(DMType),
    .Address(Address), .Write_data(Write_data), .empty(empty), .count(count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint unsigned acc_size(input logic [2:0] t);
    if (t[1:0] == 2'b00) return 1;
    if (t[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit ranges_meet(input logic [31:0] a, input logic [2:0] at,
                                     input logic [31:0] b, input logic [2:0] bt);
    longint unsigned as_, ae, bs, be;
    as_ = 64'(a); ae = as_ + acc_size(at) - 1;
    bs  = 64'(b); be = bs + acc_size(bt) - 1;
    return (as_ <= be) && (bs <= ae);
  endfunction

  function automatic bit model_push();
    return st_valid && (q.size() < 4) && (st_type inside {3'b000, 3'b001, 3'b010});
  endfunction

  function automatic bit model_stall();
    bit s = 0;
    foreach (q[k]) if (ranges_meet(q[k].a, q[k].t, ld_addr, ld_type)) s = 1;
    if (model_push() && ranges_meet(st_addr, st_type, ld_addr, ld_type)) s = 1;
    return ld_valid && s;
  endfunction

  task automatic check_all();
    bit ne;
    ne = (q.size() != 0);
    check("st_ready", st_ready, q.size() < 4);
    check("empty", empty, !ne);
    check("count", count, q.size());
    check("MemWrite", MemWrite, ne && drain_en);
    check("DMType", DMType, ne ? q[0].t : 3'd0);
    check("Address", Address, ne ? q[0].a : 32'd0);
    check("Write_data", Write_data, ne ? q[0].d : 32'd0);
    check("ld_stall", ld_stall, model_stall());
  endtask

  // One cycle: drive at negedge, check mid-low-phase, advance model at posedge.
  task automatic step(input bit sv, input logic [2:0] st, input logic [31:0] sa,
                      input logic [31:0] sd, input bit lv, input logic [2:0] lt,
                      input logic [31:0] la, input bit de);
    bit p, o;
    entry_t e;
    st_valid = sv; st_type = st; st_addr = sa; st_data = sd;
    ld_valid = lv; ld_type = lt; ld_addr = la; drain_en = de;
    #1;
    check_all();
    p = model_push();
    o = (q.size() != 0) && de;
    e.t = st; e.a = sa; e.d = sd;
    @(posedge clk);
    if (o) void'(q.pop_front());
    if (p) q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input bit de);
    step(0, 3'b010, 32'h0, 32'h0, 0, 3'b000, 32'h0, de);
  endtask

  initial begin
    rst = 1'b1; st_valid = 0; st_type = 0; st_addr = 0; st_data = 0;
    ld_valid = 0; ld_type = 0; ld_addr = 0; drain_en = 0;
    @(negedge clk); #1;
    check_all();
    check("rst_MemWrite", MemWrite, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Reset mid-drain
    step(1, 3'b010, 32'h10, 32'hA1, 0, 0, 0, 0);
    step(1, 3'b010, 32'h14, 32'hA2, 0, 0, 0, 0);
    step(1, 3'b010, 32'h18, 32'hA3, 0, 0, 0, 0);
    st_valid = 0; drain_en = 1; #1;
    check("pre_rst_MemWrite", MemWrite, 1'b1);
    #1 rst = 1'b1; #1;
    check("rst_mid_MemWrite", MemWrite, 1'b0);
    check("rst_mid_count", count, 3'd0);
    check("rst_mid_empty", empty, 1'b1);
    q.delete();
    @(posedge clk); #3 rst = 1'b0;
    @(negedge clk);
    repeat (3) idle(1);

    // Fill to full, 5th push ignored
    for (int i = 0; i < 5; i++)
      step(1, 3'b010, 32'(i*4), 32'hD000_0000 + 32'(i), 0, 0, 0, 0);
    check("full_count", count, 3'd4);
    check("full_ready", st_ready, 1'b0);

    // In-order drain
    for (int i = 0; i < 4; i++) begin
      check("drain_addr", Address, 32'(i*4));
      step(0, 3'b010, 0, 0, 0, 0, 0, 1);
    end
    check("drain_empty", empty, 1'b1);

    // Overlap stall
    step(1, 3'b001, 32'h102, 32'hBEEF, 0, 0, 0, 0);
    step(0, 3'b010, 0, 0, 1, 3'b000, 32'h103, 0);
    st_valid = 0; ld_valid = 1; ld_type = 3'b000; ld_addr = 32'h103; #1;
    check("ovl_hit", ld_stall, 1'b1);
    step(0, 3'b010, 0, 0, 1, 3'b010, 32'h104, 0);
    step(0, 3'b010, 0, 0, 1, 3'b000, 32'h103, 1);
    ld_valid = 1; ld_type = 3'b000; ld_addr = 32'h103; drain_en = 0; #1;
    check("ovl_after_drain", ld_stall, 1'b0);
    @(negedge clk);

    // Address wrap
    step(1, 3'b010, 32'hFFFF_FFFE, 32'h1234, 0, 0, 0, 0);
    step(0, 3'b010, 0, 0, 1, 3'b000, 32'h0000_0000, 0);
    step(0, 3'b010, 0, 0, 1, 3'b000, 32'hFFFF_FFFF, 0);
    ld_valid = 1; ld_addr = 32'h0; #1;
    check("wrap_low", ld_stall, 1'b0);
    ld_addr = 32'hFFFF_FFFF; #1;
    check("wrap_high", ld_stall, 1'b1);
    @(negedge clk);
    idle(1);

    // Concurrent push/pop, then an invalid store type
    step(1, 3'b010, 32'h200, 32'h1, 0, 0, 0, 0);
    step(1, 3'b010, 32'h204, 32'h2, 0, 0, 0, 0);
    step(1, 3'b000, 32'h208, 32'h3, 0, 0, 0, 1);
    check("pp_count", count, 3'd2);
    step(1, 3'b011, 32'h20C, 32'h4, 0, 0, 0, 0);
    check("bad_type_count", count, 3'd2);
    idle(1);
    check("third_addr", Address, 32'h208);
    idle(1);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      logic [31:0] sa, la;
      sa = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8 + $urandom_range(0, 7)
                                       : 32'h100 + $urandom_range(0, 15);
      la = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8 + $urandom_range(0, 7)
                                       : 32'h100 + $urandom_range(0, 15);
      step($urandom_range(0, 1), 3'($urandom_range(0, 4)), sa, $urandom,
           $urandom_range(0, 1), 3'($urandom_range(0, 7)), la,
           $urandom_range(0, 2) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
